// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the bit-serial adder (option: SERIAL_ADD_SUB_EN)
package serial_add_pkg;

  // Controller states: waiting for a request, stepping bits, reporting the result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter must reach WIDTH-1; never narrower than one bit
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fa_bit.sv
// rtl/fa_bit.sv - combinational one-bit full adder cell shared across all bit-steps
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  // Classic sum/majority full adder
  always_comb begin
    s  = a ^ b ^ c;
    co = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller, LSB first (option: SERIAL_ADD_SUB_EN adds sub port)
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  a_sr;
  logic [WIDTH-1:0]  b_sr;
  logic              carry;
  logic              fa_s;
  logic              fa_co;
  logic              accept;
  logic              last_step;
  logic [WIDTH-1:0]  b_cap;
  logic              c_cap;

  // Single shared adder cell fed from the low end of the operand shifters
  fa_bit u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .c  (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Operand B and initial carry as seen at capture; subtract is a + ~b + 1
  always_comb begin
    b_cap = b;
    c_cap = cin;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      b_cap = ~b;
      c_cap = 1'b1;
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a start outside IDLE is dropped, not queued
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last_step  = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: capture on accept, then one bit-step per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b_cap;
      carry <= c_cap;
      cnt   <= '0;
    end else if (state == RUN) begin
      sum   <= {fa_s, sum[WIDTH-1:1]};
      carry <= fa_co;
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      cnt   <= cnt + CNT_W'(1);
      if (last_step) begin
        cout <= fa_co;
      end
    end
  end

  // Status outputs decode straight from the state register
  always_comb begin
    busy = (state == RUN) || (state == DONE);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed table-driven bench for serial_add_ctrl (option: SERIAL_ADD_SUB_EN)
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks;
  int errors;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic         vsub;
    logic [W-1:0] esum;
    logic         ecout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation and wait for done; lat counts edges from the accepting edge (inclusive)
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input logic is, output int lat, output int bcnt);
    @(negedge clk);
    a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (lat < 30) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) break;
      @(posedge clk);
      lat++;
    end
  endtask

  vec_t vecs[8];
  int   lat;
  int   bcnt;
  int   npulse;
  int   first_idx;
  int   second_idx;
  logic prev_done;
  int   wide;

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum",  32'(sum),  32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub, lat, bcnt);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd9);
      chk($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].esum));
      chk($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].ecout));
      @(negedge clk);
      chk($sformatf("vec%0d_done_one_cycle", i), 32'(done), 32'd0);
      chk($sformatf("vec%0d_busy_fall", i), 32'(busy), 32'd0);
      chk($sformatf("vec%0d_sum_hold", i), 32'(sum), 32'(vecs[i].esum));
    end

    // Second start during RUN must be ignored
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h01; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    npulse = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("ignore_start_pulses", 32'(npulse), 32'd1);
    chk("ignore_start_sum", 32'(sum), 32'h96);
    chk("ignore_start_cout", 32'(cout), 32'd0);

    // Back-to-back with start held high
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
    npulse = 0; first_idx = -1; second_idx = -1; prev_done = 1'b0; wide = 0;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (done) begin
        if (prev_done) wide++;
        npulse++;
        if (first_idx < 0) first_idx = k;
        else if (second_idx < 0) second_idx = k;
      end
      prev_done = done;
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("b2b_pulses", 32'(npulse), 32'd2);
    chk("b2b_period", 32'(second_idx - first_idx), 32'd10);
    chk("b2b_wide_pulses", 32'(wide), 32'd0);
    chk("b2b_first_at", 32'(first_idx), 32'd8);

    // Reset asserted in the fourth RUN cycle
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum",  32'(sum),  32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    npulse = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || busy) npulse++;
    end
    chk("abort_no_activity", 32'(npulse), 32'd0);
    do_op(8'h12, 8'h34, 1'b1, 1'b0, lat, bcnt);
    chk("post_abort_latency", 32'(lat), 32'd9);
    chk("post_abort_sum", 32'(sum), 32'h47);
    chk("post_abort_cout", 32'(cout), 32'd0);

`ifdef SERIAL_ADD_SUB_EN
    do_op(8'h10, 8'h01, 1'b0, 1'b1, lat, bcnt);
    chk("sub1_sum", 32'(sum), 32'h0F);
    chk("sub1_cout", 32'(cout), 32'd1);
    do_op(8'h01, 8'h02, 1'b1, 1'b1, lat, bcnt);
    chk("sub2_sum", 32'(sum), 32'hFF);
    chk("sub2_cout", 32'(cout), 32'd0);
    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, lat, bcnt);
    chk("sub0_sum", 32'(sum), 32'h96);
    chk("sub0_cout", 32'(cout), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
